// File: rtl/mbufgce_ce_gen_if.sv
// Control/status bundle for the multi-channel clock-enable generator.
// The slave side is the generator; the master side drives run requests and divide values.
interface mbufgce_ce_gen_if #(
  parameter int NUM_CH = 4,
  parameter int DIV_W  = 8
);
  logic [NUM_CH-1:0]       ce;
  logic [NUM_CH*DIV_W-1:0] div;
  logic                    halt;
  logic [NUM_CH-1:0]       en_o;
  logic [NUM_CH-1:0]       run_o;
  logic                    ready_o;

  modport master (
    output ce, div, halt,
    input  en_o, run_o, ready_o
  );

  modport slave (
    input  ce, div, halt,
    output en_o, run_o, ready_o
  );
endinterface

// File: rtl/mbufgce_ce_gen.sv
// Multi-channel clock-enable generator: per-channel single-cycle strobes every div+1 cycles,
// started and stopped only at period boundaries, gated by a post-reset startup interval.
module mbufgce_ce_gen #(
  parameter int NUM_CH         = 4,
  parameter int DIV_W          = 8,
  parameter int STARTUP_CYCLES = 8
) (
  input  logic                clk_in,
  input  logic                clr_n,
  mbufgce_ce_gen_if.slave     bus
);

  localparam int SW = (STARTUP_CYCLES > 0) ? $clog2(STARTUP_CYCLES + 1) : 1;

  typedef enum logic {G_STARTUP = 1'b0, G_READY = 1'b1} gstate_t;
  typedef enum logic {CH_IDLE = 1'b0, CH_RUN = 1'b1} ch_state_t;

  gstate_t         gstate_reg;
  logic [SW-1:0]   start_cnt_reg;
  logic            ready_reg;
  logic [NUM_CH-1:0] en_vec;
  logic [NUM_CH-1:0] run_vec;

  always_ff @(posedge clk_in or negedge clr_n) begin
    if (!clr_n) begin
      gstate_reg    <= G_STARTUP;
      start_cnt_reg <= SW'(STARTUP_CYCLES);
      ready_reg     <= 1'b0;
    end else begin
      case (gstate_reg)
        G_STARTUP: begin
          if (start_cnt_reg == '0) begin
            gstate_reg <= G_READY;
            ready_reg  <= 1'b1;
          end else begin
            start_cnt_reg <= start_cnt_reg - 1'b1;
          end
        end
        G_READY: ready_reg <= 1'b1;
      endcase
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      ch_state_t        state_reg;
      logic [DIV_W-1:0] cnt_reg;
      logic [DIV_W-1:0] div_lat_reg;
      logic             en_reg;
      logic [DIV_W-1:0] div_ch;
      logic [DIV_W-1:0] cnt_inc;
      logic             ce_ch;

      assign div_ch  = bus.div[gi*DIV_W +: DIV_W];
      assign ce_ch   = bus.ce[gi];
      assign cnt_inc = cnt_reg + 1'b1;

      // en_reg is registered one edge early: it is high exactly in the cycle where cnt==div_lat.
      always_ff @(posedge clk_in or negedge clr_n) begin
        if (!clr_n) begin
          state_reg   <= CH_IDLE;
          cnt_reg     <= '0;
          div_lat_reg <= '0;
          en_reg      <= 1'b0;
        end else if (bus.halt) begin
          state_reg <= CH_IDLE;
          cnt_reg   <= '0;
          en_reg    <= 1'b0;
        end else begin
          case (state_reg)
            CH_IDLE: begin
              if (ready_reg && ce_ch) begin
                state_reg   <= CH_RUN;
                cnt_reg     <= '0;
                div_lat_reg <= div_ch;
                en_reg      <= (div_ch == '0);
              end else begin
                en_reg <= 1'b0;
              end
            end
            CH_RUN: begin
              if (cnt_reg == div_lat_reg) begin
                cnt_reg     <= '0;
                div_lat_reg <= div_ch;
                en_reg      <= ce_ch && (div_ch == '0);
                if (!ce_ch) state_reg <= CH_IDLE;
              end else begin
                cnt_reg <= cnt_inc;
                en_reg  <= (cnt_inc == div_lat_reg);
              end
            end
          endcase
        end
      end

      assign en_vec[gi]  = en_reg;
      assign run_vec[gi] = (state_reg == CH_RUN);
    end
  endgenerate

  assign bus.en_o    = en_vec;
  assign bus.run_o   = run_vec;
  assign bus.ready_o = ready_reg;

endmodule

// File: tb/tb_mbufgce_ce_gen.sv
// Directed bench for mbufgce_ce_gen: startup gating, divide ratios, boundary stop/restart,
// mid-period divide change, halt priority and asynchronous reset replay.
module tb_mbufgce_ce_gen;

  localparam int NUM_CH         = 4;
  localparam int DIV_W          = 8;
  localparam int STARTUP_CYCLES = 8;

  logic clk_in = 1'b0;
  logic clr_n  = 1'b0;
  int   total  = 0;
  int   bad    = 0;

  mbufgce_ce_gen_if #(.NUM_CH(NUM_CH), .DIV_W(DIV_W)) bus ();

  mbufgce_ce_gen #(
    .NUM_CH(NUM_CH),
    .DIV_W(DIV_W),
    .STARTUP_CYCLES(STARTUP_CYCLES)
  ) dut (
    .clk_in(clk_in),
    .clr_n(clr_n),
    .bus(bus)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end else begin
      $display("ok   %s: %0h", tag, obs);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic quiesce();
    bus.ce   = '0;
    bus.halt = 1'b1;
    tick();
    check("halt_clear_run", 32'(bus.run_o), 32'h0);
    bus.halt = 1'b0;
  endtask

  int cnt_seen [NUM_CH];
  int last_seen[NUM_CH];
  int sp_err   [NUM_CH];
  int div_tab  [NUM_CH] = '{0, 1, 3, 255};
  int exp_cnt  [NUM_CH] = '{1024, 512, 256, 4};

  initial begin
    bus.ce   = '0;
    bus.div  = '0;
    bus.halt = 1'b0;

    // reset state
    tick();
    tick();
    check("rst_ready", 32'(bus.ready_o), 32'h0);
    check("rst_run",   32'(bus.run_o),   32'h0);
    check("rst_en",    32'(bus.en_o),    32'h0);

    // startup gating with ce held high from release
    bus.ce  = 4'hF;
    bus.div = {8'd255, 8'd3, 8'd1, 8'd0};
    #2 clr_n = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      check($sformatf("startup_ready_e%0d", k), 32'(bus.ready_o), 32'h0);
      check($sformatf("startup_run_e%0d", k),   32'(bus.run_o),   32'h0);
      check($sformatf("startup_en_e%0d", k),    32'(bus.en_o),    32'h0);
    end
    tick();
    check("ready_e9", 32'(bus.ready_o), 32'h1);
    check("run_e9",   32'(bus.run_o),   32'h0);
    tick();
    check("run_e10",  32'(bus.run_o),   32'hF);
    check("en_e10",   32'(bus.en_o),    32'h1);

    // divide ratios over 1024 cycles
    for (int ch = 0; ch < NUM_CH; ch++) begin
      cnt_seen[ch] = 0; last_seen[ch] = 0; sp_err[ch] = 0;
    end
    for (int c = 1; c <= 1024; c++) begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        if (bus.en_o[ch] === 1'b1) begin
          cnt_seen[ch]++;
          if (c - last_seen[ch] != div_tab[ch] + 1) sp_err[ch]++;
          last_seen[ch] = c;
        end
      end
      tick();
    end
    for (int ch = 0; ch < NUM_CH; ch++) begin
      check($sformatf("div_count_ch%0d", ch),   32'(cnt_seen[ch]), 32'(exp_cnt[ch]));
      check($sformatf("div_spacing_ch%0d", ch), 32'(sp_err[ch]),   32'h0);
    end
    quiesce();

    // boundary stop: drop ce at cnt=1, final strobe at cnt=3
    bus.div = {8'd0, 8'd0, 8'd3, 8'd0};
    bus.ce  = 4'b0010;
    tick();
    check("stop_start_run", 32'(bus.run_o), 32'h2);
    tick();
    bus.ce = 4'b0000;
    tick();
    check("stop_cnt2_en", 32'(bus.en_o), 32'h0);
    tick();
    check("stop_final_en",  32'(bus.en_o),  32'h2);
    check("stop_final_run", 32'(bus.run_o), 32'h2);
    tick();
    check("stop_after_run", 32'(bus.run_o), 32'h0);
    check("stop_after_en",  32'(bus.en_o),  32'h0);
    for (int k = 0; k < 4; k++) tick();
    check("stop_quiet_en", 32'(bus.en_o), 32'h0);

    // glitch-free restart: drop at cnt=1, re-assert at cnt=2
    bus.ce = 4'b0010;
    tick();
    tick();
    bus.ce = 4'b0000;
    tick();
    bus.ce = 4'b0010;
    tick();
    check("restart_first_en", 32'(bus.en_o[1]), 32'h1);
    for (int k = 1; k <= 8; k++) begin
      tick();
      check($sformatf("restart_en_k%0d", k), 32'(bus.en_o[1]), (k % 4 == 0) ? 32'h1 : 32'h0);
    end
    quiesce();

    // divide change 3->7 at cnt=1
    bus.div = {8'd0, 8'd0, 8'd3, 8'd0};
    bus.ce  = 4'b0010;
    tick();
    tick();
    bus.div = {8'd0, 8'd0, 8'd7, 8'd0};
    tick();
    tick();
    check("divchg_first_en", 32'(bus.en_o[1]), 32'h1);
    for (int k = 1; k <= 16; k++) begin
      tick();
      check($sformatf("divchg_en_k%0d", k), 32'(bus.en_o[1]), (k % 8 == 0) ? 32'h1 : 32'h0);
    end
    quiesce();

    // halt sampled at the edge opening a common boundary cycle
    bus.div = {4{8'd3}};
    bus.ce  = 4'hF;
    tick();
    tick();
    tick();
    bus.halt = 1'b1;
    tick();
    check("halt_en",    32'(bus.en_o),    32'h0);
    check("halt_run",   32'(bus.run_o),   32'h0);
    check("halt_ready", 32'(bus.ready_o), 32'h1);
    bus.halt = 1'b0;
    tick();
    check("halt_restart_run", 32'(bus.run_o), 32'hF);
    check("halt_restart_en",  32'(bus.en_o),  32'h0);
    tick();
    tick();
    tick();
    check("halt_inphase_en", 32'(bus.en_o), 32'hF);

    // asynchronous reset between edges, then startup replay
    #2 clr_n = 1'b0;
    #1;
    check("arst_en",    32'(bus.en_o),    32'h0);
    check("arst_run",   32'(bus.run_o),   32'h0);
    check("arst_ready", 32'(bus.ready_o), 32'h0);
    tick();
    tick();
    #3 clr_n = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      check($sformatf("replay_ready_e%0d", k), 32'(bus.ready_o), 32'h0);
    end
    tick();
    check("replay_ready_e9", 32'(bus.ready_o), 32'h1);
    tick();
    check("replay_run_e10", 32'(bus.run_o), 32'hF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
